// File: rtl/alu_mc_pkg.sv
// Shared types and constants for the multi-cycle ALU.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADC  = 4'd1,
        OP_SUB  = 4'd2,
        OP_SBC  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_INV  = 4'd7,
        OP_TWC  = 4'd8,
        OP_INC  = 4'd9,
        OP_DEC  = 4'd10,
        OP_LSR  = 4'd11,
        OP_ASR  = 4'd12,
        OP_MOV  = 4'd13,
        OP_MUL  = 4'd14,
        OP_MULS = 4'd15
    } op_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // True for the two ops that go through the sequential multiplier.
    function automatic logic is_mul_op(input op_t op);
        return (op == OP_MUL) || (op == OP_MULS);
    endfunction

endpackage

// File: rtl/alu_mc_mult_seq.sv
// Radix-2 shift-add unsigned multiplier: one partial product per step.
// The accumulator holds {upper partial sum, remaining multiplier bits}.
module mult_seq #(
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic                         step,
    input  logic [WIDTH-1:0]             mcand,
    input  logic [WIDTH-1:0]             mplier,
    output logic [2*WIDTH-1:0]           product,
    output logic [$clog2(WIDTH+1)-1:0]   count
);

    localparam int CW = $clog2(WIDTH+1);

    logic [WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [CW-1:0]      count_r;
    logic [WIDTH:0]     partial_s;

    // Upper accumulator word plus the multiplicand gated by the current multiplier bit.
    always_comb begin
        partial_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                  + ({1'b0, mcand_r} & {(WIDTH+1){acc_r[0]}});
    end

    // Load the operands, or retire one multiplier bit and shift right.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_r <= {WIDTH{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            count_r <= {CW{1'b0}};
        end else if (load) begin
            mcand_r <= mcand;
            acc_r   <= {{WIDTH{1'b0}}, mplier};
            count_r <= CW'(WIDTH);
        end else if (step) begin
            acc_r   <= {partial_s, acc_r[WIDTH-1:1]};
            count_r <= count_r - CW'(1);
        end
    end

    assign product = acc_r;
    assign count   = count_r;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic ops plus a sequential
// unsigned/signed multiplier, with a start/done handshake and Z/N/C/V flags.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);

    localparam int CW = $clog2(WIDTH+1);
    localparam int PW = 2*WIDTH;

    state_t           state_r, state_s;
    logic             accept_s, load_s, step_s, cap_single_s, cap_mul_s;
    logic [CW-1:0]    count_s;
    logic [PW-1:0]    product_s;
    logic [WIDTH-1:0] mag_a_s, mag_b_s;
    logic             neg_r, signed_r;

    logic [WIDTH-1:0] add_x_s, add_y_s;
    logic             add_c_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s, alu_v_s;
    logic [3:0]       alu_flags_s;

    logic [PW-1:0]    prod_fix_s;
    logic [WIDTH-1:0] prod_hi_s, prod_lo_s;
    logic [3:0]       mul_flags_s;

    logic [WIDTH-1:0] result_lo_r, result_hi_r;
    logic [3:0]       flags_r;
    logic             done_r;

    assign ready    = (state_r == ST_IDLE);
    assign accept_s = start && (state_r == ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: multiply walks IDLE -> MUL (WIDTH steps) -> FIN -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_op(op)) begin
                    state_s = ST_MUL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (count_s == CW'(1)) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Control strobes decoded from the current state and the accepted op.
    always_comb begin
        load_s       = 1'b0;
        step_s       = 1'b0;
        cap_single_s = 1'b0;
        cap_mul_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_mul_op(op)) begin
                        load_s = 1'b1;
                    end else begin
                        cap_single_s = 1'b1;
                    end
                end else begin
                    load_s       = 1'b0;
                    cap_single_s = 1'b0;
                end
            end
            ST_MUL:  step_s    = 1'b1;
            ST_FIN:  cap_mul_s = 1'b1;
            default: begin
                load_s    = 1'b0;
                step_s    = 1'b0;
                cap_mul_s = 1'b0;
            end
        endcase
    end

    // Signed multiply feeds magnitudes to the core; the sign is restored in FIN.
    always_comb begin
        mag_a_s = a;
        mag_b_s = b;
        if (op == OP_MULS) begin
            if (a[WIDTH-1]) begin
                mag_a_s = ~a + WIDTH'(1);
            end else begin
                mag_a_s = a;
            end
            if (b[WIDTH-1]) begin
                mag_b_s = ~b + WIDTH'(1);
            end else begin
                mag_b_s = b;
            end
        end else begin
            mag_a_s = a;
            mag_b_s = b;
        end
    end

    // Remember signedness and result sign of the multiply in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            neg_r    <= 1'b0;
            signed_r <= 1'b0;
        end else if (load_s) begin
            signed_r <= (op == OP_MULS);
            neg_r    <= (op == OP_MULS) && (a[WIDTH-1] ^ b[WIDTH-1]);
        end
    end

    mult_seq #(.WIDTH(WIDTH)) u_mult (
        .clk     (clk),
        .reset   (reset),
        .load    (load_s),
        .step    (step_s),
        .mcand   (mag_a_s),
        .mplier  (mag_b_s),
        .product (product_s),
        .count   (count_s)
    );

    // Adder operand selection; every add/sub style op shares one WIDTH+1 adder.
    always_comb begin
        add_x_s = a;
        add_y_s = b;
        add_c_s = 1'b0;
        case (op)
            OP_ADD: begin add_y_s = b;  add_c_s = 1'b0; end
            OP_ADC: begin add_y_s = b;  add_c_s = cin;  end
            OP_SUB: begin add_y_s = ~b; add_c_s = 1'b1; end
            OP_SBC: begin add_y_s = ~b; add_c_s = cin;  end
            OP_TWC: begin add_x_s = ~a; add_y_s = {WIDTH{1'b0}}; add_c_s = 1'b1; end
            OP_INC: begin add_y_s = {WIDTH{1'b0}}; add_c_s = 1'b1; end
            OP_DEC: begin add_y_s = {WIDTH{1'b1}}; add_c_s = 1'b0; end
            default: begin
                add_x_s = a;
                add_y_s = b;
                add_c_s = 1'b0;
            end
        endcase
        sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{WIDTH{1'b0}}, add_c_s};
    end

    // Single-cycle result and flags; unknown/multiply codes fall back to MOV.
    always_comb begin
        alu_res_s = a;
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_TWC, OP_INC, OP_DEC: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = (add_x_s[WIDTH-1] == add_y_s[WIDTH-1])
                         && (sum_s[WIDTH-1] != add_x_s[WIDTH-1]);
            end
            OP_AND: alu_res_s = a & b;
            OP_OR:  alu_res_s = a | b;
            OP_XOR: alu_res_s = a ^ b;
            OP_INV: alu_res_s = ~a;
            OP_LSR: begin
                alu_res_s = {1'b0, a[WIDTH-1:1]};
                alu_c_s   = a[0];
            end
            OP_ASR: begin
                alu_res_s = {a[WIDTH-1], a[WIDTH-1:1]};
                alu_c_s   = a[0];
            end
            OP_MOV:  alu_res_s = a;
            default: alu_res_s = a;
        endcase
        alu_flags_s         = 4'b0000;
        alu_flags_s[FLAG_Z] = (alu_res_s == {WIDTH{1'b0}});
        alu_flags_s[FLAG_N] = alu_res_s[WIDTH-1];
        alu_flags_s[FLAG_C] = alu_c_s;
        alu_flags_s[FLAG_V] = alu_v_s;
    end

    // FIN fix-up: negate the magnitude product when operand signs differed.
    always_comb begin
        if (neg_r) begin
            prod_fix_s = ~product_s + PW'(1);
        end else begin
            prod_fix_s = product_s;
        end
        prod_hi_s = prod_fix_s[PW-1:WIDTH];
        prod_lo_s = prod_fix_s[WIDTH-1:0];
        mul_flags_s         = 4'b0000;
        mul_flags_s[FLAG_Z] = (prod_fix_s == {PW{1'b0}});
        mul_flags_s[FLAG_N] = prod_hi_s[WIDTH-1];
        mul_flags_s[FLAG_C] = 1'b0;
        if (signed_r) begin
            mul_flags_s[FLAG_V] = (prod_hi_s != {WIDTH{prod_lo_s[WIDTH-1]}});
        end else begin
            mul_flags_s[FLAG_V] = (prod_hi_s != {WIDTH{1'b0}});
        end
    end

    // Output registers: updated only on completion, done pulses for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_lo_r <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            flags_r     <= 4'b0000;
            done_r      <= 1'b0;
        end else if (cap_single_s) begin
            result_lo_r <= alu_res_s;
            result_hi_r <= {WIDTH{1'b0}};
            flags_r     <= alu_flags_s;
            done_r      <= 1'b1;
        end else if (cap_mul_s) begin
            result_lo_r <= prod_lo_s;
            result_hi_r <= prod_hi_s;
            flags_r     <= mul_flags_s;
            done_r      <= 1'b1;
        end else begin
            done_r      <= 1'b0;
        end
    end

    assign result_lo = result_lo_r;
    assign result_hi = result_hi_r;
    assign flags     = flags_r;
    assign done      = done_r;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: scoreboard on the 16-bit instance,
// directed latency/result checks on an 8-bit instance.
module tb_alu_mc;
    import alu_mc_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, cin;
    op_t         op;
    logic [15:0] a, b, result_lo, result_hi;
    logic [3:0]  flags;
    logic        ready, done;

    logic        start8, cin8;
    op_t         op8;
    logic [7:0]  a8, b8, result_lo8, result_hi8;
    logic [3:0]  flags8;
    logic        ready8, done8;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    typedef struct packed {
        logic [15:0] lo;
        logic [15:0] hi;
        logic [3:0]  fl;
        logic [31:0] at;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    exp_t  mon_e;
    string mon_t;

    alu_mc #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .ready(ready), .done(done), .result_lo(result_lo), .result_hi(result_hi), .flags(flags)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .done(done8), .result_lo(result_lo8), .result_hi(result_hi8), .flags(flags8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Scoreboard: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_done observed=1 expected=0 cycle=%0d", cyc);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                check({mon_t, "_cycle"}, cyc, mon_e.at);
                check({mon_t, "_lo"}, 32'(result_lo), 32'(mon_e.lo));
                check({mon_t, "_hi"}, 32'(result_hi), 32'(mon_e.hi));
                check({mon_t, "_flags"}, 32'(flags), 32'(mon_e.fl));
            end
        end
    end

    // Drive one start for a cycle; a tracked op pushes its expected result and done cycle.
    task automatic issue(input op_t o, input logic [15:0] ia, input logic [15:0] ib,
                         input logic ic, input string tag, input logic [15:0] elo,
                         input logic [15:0] ehi, input logic [3:0] efl, input bit track);
        logic [31:0] lat;
        lat = is_mul_op(o) ? 32'd18 : 32'd1;
        op = o; a = ia; b = ib; cin = ic; start = 1'b1;
        if (track) begin
            tag_q.push_back(tag);
            exp_q.push_back({elo, ehi, efl, cyc + lat});
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        int n_done;
        reset = 1'b1; start = 1'b0; op = OP_ADD; a = 16'h0; b = 16'h0; cin = 1'b0;
        start8 = 1'b0; op8 = OP_ADD; a8 = 8'h0; b8 = 8'h0; cin8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done",  32'(done), 32'd0);
        check("rst_lo",    32'(result_lo), 32'd0);
        check("rst_hi",    32'(result_hi), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);

        // Single-cycle ops, back to back: flags are {V,C,N,Z}.
        issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, "add_wrap", 16'h0000, 16'h0, 4'h5, 1'b1);
        issue(OP_SUB, 16'h8000, 16'h0001, 1'b0, "sub_ovf",  16'h7FFF, 16'h0, 4'hC, 1'b1);
        issue(OP_SBC, 16'h0005, 16'h0003, 1'b0, "sbc",      16'h0001, 16'h0, 4'h4, 1'b1);
        issue(OP_AND, 16'hF0F0, 16'h3C3C, 1'b0, "and",      16'h3030, 16'h0, 4'h0, 1'b1);
        issue(OP_OR,  16'hF0F0, 16'h0F0F, 1'b0, "or",       16'hFFFF, 16'h0, 4'h2, 1'b1);
        issue(OP_XOR, 16'h1234, 16'h1234, 1'b0, "xor_zero", 16'h0000, 16'h0, 4'h1, 1'b1);
        issue(OP_ADC, 16'h7FFF, 16'h0000, 1'b1, "adc_ovf",  16'h8000, 16'h0, 4'hA, 1'b1);
        issue(OP_INV, 16'h00FF, 16'h0000, 1'b0, "inv",      16'hFF00, 16'h0, 4'h2, 1'b1);
        issue(OP_TWC, 16'h0001, 16'h0000, 1'b0, "twc",      16'hFFFF, 16'h0, 4'h2, 1'b1);
        issue(OP_INC, 16'h0010, 16'h0000, 1'b0, "inc",      16'h0011, 16'h0, 4'h0, 1'b1);
        issue(OP_DEC, 16'h0000, 16'h0000, 1'b0, "dec",      16'hFFFF, 16'h0, 4'h2, 1'b1);
        issue(OP_LSR, 16'h8001, 16'h0000, 1'b0, "lsr",      16'h4000, 16'h0, 4'h4, 1'b1);
        issue(OP_ASR, 16'h8001, 16'h0000, 1'b0, "asr",      16'hC000, 16'h0, 4'h6, 1'b1);
        issue(OP_MOV, 16'h0000, 16'hFFFF, 1'b0, "mov_zero", 16'h0000, 16'h0, 4'h1, 1'b1);
        drain("single");

        // Unsigned multiply; an ADD pulsed mid-operation must be ignored.
        issue(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, "mul_max", 16'h0001, 16'hFFFE, 4'hA, 1'b1);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            n++;
            op = OP_ADD; a = 16'h1111; b = 16'h2222;
            start = (n == 5);
            @(negedge clk);
        end
        start = 1'b0;
        check("mul_ready_low", n, 32'd17);

        // New start on the edge that ends the done cycle.
        issue(OP_MULS, 16'hFFFD, 16'h0007, 1'b0, "muls_neg",  16'hFFEB, 16'hFFFF, 4'h2, 1'b1);
        drain("muls_neg");
        issue(OP_MULS, 16'h8000, 16'h8000, 1'b0, "muls_min",  16'h0000, 16'h4000, 4'h8, 1'b1);
        drain("muls_min");
        issue(OP_MUL,  16'h0000, 16'h1234, 1'b0, "mul_zero",  16'h0000, 16'h0000, 4'h1, 1'b1);
        drain("mul_zero");

        // Outputs hold between operations.
        issue(OP_MOV, 16'hBEEF, 16'h0000, 1'b0, "mov_beef", 16'hBEEF, 16'h0, 4'h2, 1'b1);
        drain("mov_beef");
        repeat (3) @(negedge clk);
        check("hold_lo", 32'(result_lo), 32'h0000BEEF);
        check("hold_done", 32'(done), 32'd0);

        // Reset at iteration 5 of a multiply: abandoned with no done.
        issue(OP_MUL, 16'h1234, 16'h5678, 1'b0, "mul_abort", 16'h0, 16'h0, 4'h0, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done",  32'(done), 32'd0);
        check("abort_lo",    32'(result_lo), 32'd0);
        check("abort_hi",    32'(result_hi), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        n_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("abort_no_done", n_done, 32'd0);
        issue(OP_ADD, 16'h0001, 16'h0002, 1'b0, "add_after_rst", 16'h0003, 16'h0, 4'h0, 1'b1);
        drain("after_rst");

        // WIDTH=8: done lands after edge k+WIDTH+1, i.e. the 10th falling edge after the drive.
        op8 = OP_MUL; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (done8 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("w8_mul_latency", n, 32'd10);
        check("w8_mul_hi",    32'(result_hi8), 32'h000000FE);
        check("w8_mul_lo",    32'(result_lo8), 32'h00000001);
        check("w8_mul_flags", 32'(flags8), 32'hA);
        @(negedge clk);
        check("w8_done_single", 32'(done8), 32'd0);

        op8 = OP_ASR; a8 = 8'h81; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("w8_asr_done",  32'(done8), 32'd1);
        check("w8_asr_lo",    32'(result_lo8), 32'h000000C0);
        check("w8_asr_hi",    32'(result_hi8), 32'd0);
        check("w8_asr_flags", 32'(flags8), 32'h6);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the CPU execute stage. It replaces the purely combinational datapath with a registered unit that has a start/done handshake, arithmetic flags, and a sequential unsigned/signed multiplier producing a double-width product. Single-cycle ops complete in one clock. MUL/MULS iterate one bit per clock, so no combinational multiplier is needed.

## Interface
- `WIDTH`, 16: operand and result-word width; must be ≥ 4.
- `clk`  in  1: system clock.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: launch an operation; accepted only when `ready` = 1.
- `op`  in  4: operation code (`alu_mc_pkg::op_t`), sampled with `start`.
- `a`, `b`  in  WIDTH each: operands, captured on the accepting edge.
- `cin`  in  1: carry in for ADC/SBC, captured with the operands.
- `ready`  out  1: high in IDLE.
- `done`  out  1: one-cycle pulse when the result and flags are valid.
- `result_lo`  out  WIDTH: result, or the low product word.
- `result_hi`  out  WIDTH: high product word; 0 for non-multiply ops.
- `flags`  out  4: [0] Z, [1] N, [2] C, [3] V.

## Operation
- Ops:
  - ADD: a+b. ADC: a+b+cin.
  - SUB: a+~b+1. SBC: a+~b+cin.
  - AND, OR, XOR: bitwise.
  - INV: ~a. TWC: ~a+1. INC: a+1. DEC: a+~0.
  - LSR: logical shift right of a by 1. ASR: arithmetic shift right of a by 1. MOV: a.
  - MUL: unsigned a×b. MULS: two's-complement a×b.
- Undefined op codes behave as MOV.
- Add/sub arithmetic is computed at WIDTH+1 bits.
  - C is bit WIDTH of that sum, so C = 1 on subtract means no borrow.
  - V = signed overflow: operands of equal sign (after b inversion) whose result sign differs.
- LSR/ASR: C = a[0]. V = 0.
- Logic ops, INV and MOV: C = 0, V = 0.
- All non-multiply ops: Z = (result_lo == 0), N = result_lo[WIDTH-1].
- MUL/MULS flags:
  - Z is set when the full 2·WIDTH product is 0.
  - N = result_hi[WIDTH-1]. C = 0.
  - MUL: V = (result_hi != 0).
  - MULS: V = 1 when result_hi is not the sign extension of result_lo[WIDTH-1].
- MULS: operand magnitudes are multiplied unsigned. The product is negated in FIN if the operand signs differ.
- States:
  - IDLE: `ready` = 1.
    - start with a single-cycle op: compute, register the outputs, pulse done, stay in IDLE.
    - start with MUL/MULS: load the operands, counter = WIDTH, go to MUL.
  - MUL: one shift-add iteration per cycle, counter decrements, go to FIN at count 0.
  - FIN: sign fix-up; register the result and flags; pulse done; go to IDLE.
- `start` while not `ready` is ignored: no queuing and no effect on the current operation.
- Outputs hold their last values until the next done.
- `reset`:
  - State goes to IDLE; result_lo, result_hi, flags and done go to 0; `ready` = 1 on the following cycle.
  - Any in-flight multiply is abandoned without a done.
  - Reset has priority over `start` in the same cycle.

## Timing
- Let k be the accepting edge, with `start` = 1 and `ready` = 1.
- Single-cycle ops:
  - done = 1 in the cycle after edge k; latency is 1.
  - Back-to-back starts on consecutive cycles are allowed, giving one result per cycle.
- MUL/MULS:
  - `ready` = 0 from after edge k until done.
  - The MUL state takes WIDTH cycles and FIN takes 1 cycle.
  - done is high in the cycle after edge k+WIDTH+1; latency is WIDTH+1.
  - `ready` returns high in the same cycle as done, so a new start may be accepted on the edge that ends the done cycle.
- done is never high for two consecutive cycles from a single start.

## Structure
- `alu_mc_pkg`:
  - `op_t` enum, 4 bits: ADD=0, ADC, SUB, SBC, AND, OR, XOR, INV, TWC, INC, DEC, LSR, ASR, MOV, MUL, MULS=15.
  - Flag index constants FLAG_Z, FLAG_N, FLAG_C, FLAG_V.
  - State enum: IDLE, MUL, FIN.
- Sub-module `mult_seq`, parametrised by WIDTH:
  - Radix-2 shift-add core with load/step inputs, a counter, and a 2·WIDTH accumulator.
  - `alu_mc` owns the FSM, sign handling and flags.

## Test plan
- ADD a=0xFFFF, b=0x0001 → result_lo=0x0000, Z=1, C=1, N=0, V=0; done exactly 1 cycle after start.
- SUB a=0x8000, b=0x0001 → 0x7FFF, C=1, V=1, N=0. SBC a=0x0005, b=0x0003, cin=0 → 0x0001, C=1.
- MUL a=0xFFFF, b=0xFFFF → result_hi=0xFFFE, result_lo=0x0001, V=1, C=0.
  - `ready` low for exactly 17 cycles; done exactly 17 cycles after start.
- MULS a=0xFFFD (−3), b=0x0007 → result_hi=0xFFFF, result_lo=0xFFEB, N=1, V=0, Z=0.
- start with ADD pulsed mid-MUL → ignored; the MUL result is unaffected.
  - reset asserted at iteration 5 of a MUL → no done; outputs 0; `ready`=1 the next cycle.
- WIDTH=8 instance: MUL 0xFF×0xFF → result_hi=0xFE, result_lo=0x01, done 9 cycles after start; ASR 0x81 → 0xC0, C=1.
